screen_scan_arbiter: RTL and testbench

- Owns the single port of the Hack screen RAM: 8192 x 16-bit words, 512x256 pixels at 1 bpp, 1-cycle registered read.
- Shares that port between the CPU memory-mapped screen access and the LCD scan-out fetch.
- Converts the rgb_lcd timing outputs (de, h_pos, v_pos) into RGB565 pixels.
- Sits in top between computer, rgb_lcd and the screen RAM. Replaces the fixed colour-bar generator.

---
 rtl/screen_pkg.sv | 28 ++
 rtl/screen_pixel_pipe.sv | 106 ++++++++++
 rtl/screen_scan_arbiter.sv | 110 +++++++++++
 tb/tb_screen_scan_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/screen_pkg.sv
// Shared geometry, widths and types for the Hack screen scan-out path.
// Consumed by the arbiter top and the pixel pipeline.
package screen_pkg;

  localparam int SCREEN_ADDR_W        = 13;
  localparam int SCREEN_WORDS_PER_ROW = 32;
  localparam int SCREEN_ROWS          = 256;
  localparam int PIX_PER_WORD         = 16;

  localparam int POS_W     = 10;
  localparam int WORD_W    = 16;
  localparam int PIX_IDX_W = $clog2(PIX_PER_WORD);
  localparam int COL_IDX_W = $clog2(SCREEN_WORDS_PER_ROW);
  localparam int ROW_IDX_W = $clog2(SCREEN_ROWS);

  typedef logic [15:0]              rgb565_t;
  typedef logic [WORD_W-1:0]        screen_word_t;
  typedef logic [SCREEN_ADDR_W-1:0] screen_addr_t;

  // Row-major word address: 32 words per 512-pixel row.
  function automatic screen_addr_t screen_word_addr(
    input logic [ROW_IDX_W-1:0] row,
    input logic [COL_IDX_W-1:0] col
  );
    return {row, col};
  endfunction

endpackage

// File: rtl/screen_pixel_pipe.sv
// Video stages 1-2: holds the fetched screen word, selects the pixel bit and
// maps it to RGB565 while delaying de/hs/vs by the same two cycles.
module screen_pixel_pipe
  import screen_pkg::*;
#(
  parameter rgb565_t FG_COLOR     = 16'h0000,
  parameter rgb565_t BG_COLOR     = 16'hFFFF,
  parameter rgb565_t BORDER_COLOR = 16'h001F
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_de,
  input  logic                 i_hs,
  input  logic                 i_vs,
  input  logic [PIX_IDX_W-1:0] i_x,
  input  logic                 i_y_in_screen,
  input  logic                 i_fetch,
  input  screen_word_t         i_ram_rdata,
  output logic                 o_de,
  output logic                 o_hs,
  output logic                 o_vs,
  output rgb565_t              o_rgb
);

  function automatic rgb565_t pixel_color(
    input logic de,
    input logic y_in_screen,
    input logic pix_bit
  );
    rgb565_t c;
    if (!de)               c = 16'h0000;
    else if (!y_in_screen) c = BORDER_COLOR;
    else if (pix_bit)      c = FG_COLOR;
    else                   c = BG_COLOR;
    return c;
  endfunction

  logic                 r_de_p1;
  logic                 r_hs_p1;
  logic                 r_vs_p1;
  logic [PIX_IDX_W-1:0] r_x_p1;
  logic                 r_y_in_screen_p1;
  logic                 r_fetch_p1;
  screen_word_t         r_word_p1;

  logic                 r_de_p2;
  logic                 r_hs_p2;
  logic                 r_vs_p2;
  rgb565_t              r_rgb_p2;

  screen_word_t         w_word_p1;
  logic                 w_bit_p1;

  // ---- stage 0 -> stage 1: register timing and the fetch marker ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_de_p1          <= 1'b0;
      r_hs_p1          <= 1'b0;
      r_vs_p1          <= 1'b0;
      r_x_p1           <= '0;
      r_y_in_screen_p1 <= 1'b0;
      r_fetch_p1       <= 1'b0;
    end else begin
      r_de_p1          <= i_de;
      r_hs_p1          <= i_hs;
      r_vs_p1          <= i_vs;
      r_x_p1           <= i_x;
      r_y_in_screen_p1 <= i_y_in_screen;
      r_fetch_p1       <= i_fetch;
    end
  end

  // RAM data lands one cycle after the fetch; use it immediately and keep it
  // for the remaining 15 pixels of the word.
  assign w_word_p1 = r_fetch_p1 ? i_ram_rdata : r_word_p1;
  assign w_bit_p1  = w_word_p1[r_x_p1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_word_p1 <= '0;
    end else begin
      r_word_p1 <= w_word_p1;
    end
  end

  // ---- stage 1 -> stage 2: colour mux and aligned timing ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_de_p2  <= 1'b0;
      r_hs_p2  <= 1'b0;
      r_vs_p2  <= 1'b0;
      r_rgb_p2 <= '0;
    end else begin
      r_de_p2  <= r_de_p1;
      r_hs_p2  <= r_hs_p1;
      r_vs_p2  <= r_vs_p1;
      r_rgb_p2 <= pixel_color(r_de_p1, r_y_in_screen_p1, w_bit_p1);
    end
  end

  assign o_de  = r_de_p2;
  assign o_hs  = r_hs_p2;
  assign o_vs  = r_vs_p2;
  assign o_rgb = r_rgb_p2;

endmodule

// File: rtl/screen_scan_arbiter.sv
// Single-port screen RAM owner: display fetch has fixed priority over CPU
// access; scan-out words are turned into RGB565 by screen_pixel_pipe.
module screen_scan_arbiter
  import screen_pkg::*;
#(
  parameter rgb565_t FG_COLOR     = 16'h0000,
  parameter rgb565_t BG_COLOR     = 16'hFFFF,
  parameter rgb565_t BORDER_COLOR = 16'h001F
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     lcd_de_in,
  input  logic                     lcd_hs_in,
  input  logic                     lcd_vs_in,
  input  logic [POS_W-1:0]         h_pos,
  input  logic [POS_W-1:0]         v_pos,
  output logic                     lcd_de,
  output logic                     lcd_hs,
  output logic                     lcd_vs,
  output rgb565_t                  lcd_rgb,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [SCREEN_ADDR_W-1:0] cpu_addr,
  input  logic [WORD_W-1:0]        cpu_wdata,
  output logic                     cpu_ready,
  output logic [WORD_W-1:0]        cpu_rdata,
  output logic                     cpu_rvalid,
  output logic                     ram_en,
  output logic                     ram_we,
  output logic [SCREEN_ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0]        ram_wdata,
  input  logic [WORD_W-1:0]        ram_rdata
);

  logic         w_y_in_screen;
  logic         w_fetch;
  logic         w_cpu_grant;
  screen_addr_t w_fetch_addr;
  logic         w_unused;

  logic         r_rd_pend_p1;
  screen_word_t r_rdata_hold;

  // Columns 512+ never appear on the 480-wide panel, so h_pos[9] is not needed.
  assign w_unused = h_pos[POS_W-1];

  assign w_y_in_screen = (v_pos < POS_W'(SCREEN_ROWS));
  assign w_fetch       = lcd_de_in && (h_pos[PIX_IDX_W-1:0] == '0) && w_y_in_screen;
  assign w_fetch_addr  = screen_word_addr(v_pos[ROW_IDX_W-1:0],
                                          h_pos[PIX_IDX_W+COL_IDX_W-1:PIX_IDX_W]);
  assign w_cpu_grant   = cpu_req && !w_fetch;
  assign cpu_ready     = w_cpu_grant;

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    if (w_fetch) begin
      ram_en   = 1'b1;
      ram_addr = w_fetch_addr;
    end else if (w_cpu_grant) begin
      ram_en = 1'b1;
      ram_we = cpu_we;
    end
  end

  // ---- CPU read return: grant cycle -> data cycle ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_pend_p1 <= 1'b0;
    end else begin
      r_rd_pend_p1 <= w_cpu_grant && !cpu_we;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata_hold <= '0;
    end else if (r_rd_pend_p1) begin
      r_rdata_hold <= ram_rdata;
    end
  end

  // The RAM's own output register supplies the data in the rvalid cycle;
  // the hold register keeps it stable afterwards.
  assign cpu_rvalid = r_rd_pend_p1;
  assign cpu_rdata  = r_rd_pend_p1 ? ram_rdata : r_rdata_hold;

  screen_pixel_pipe #(
    .FG_COLOR     (FG_COLOR),
    .BG_COLOR     (BG_COLOR),
    .BORDER_COLOR (BORDER_COLOR)
  ) u_pixel_pipe (
    .clk           (clk),
    .reset         (reset),
    .i_de          (lcd_de_in),
    .i_hs          (lcd_hs_in),
    .i_vs          (lcd_vs_in),
    .i_x           (h_pos[PIX_IDX_W-1:0]),
    .i_y_in_screen (w_y_in_screen),
    .i_fetch       (w_fetch),
    .i_ram_rdata   (ram_rdata),
    .o_de          (lcd_de),
    .o_hs          (lcd_hs),
    .o_vs          (lcd_vs),
    .o_rgb         (lcd_rgb)
  );

endmodule

// File: tb/tb_screen_scan_arbiter.sv
// Directed bench for screen_scan_arbiter with a behavioural 1-cycle screen RAM.
module tb_screen_scan_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        lcd_de_in, lcd_hs_in, lcd_vs_in;
  logic [9:0]  h_pos, v_pos;
  logic        lcd_de, lcd_hs, lcd_vs;
  logic [15:0] lcd_rgb;
  logic        cpu_req, cpu_we;
  logic [12:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ready;
  logic [15:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        ram_en, ram_we;
  logic [12:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata = 16'h0000;

  bit   [15:0] mem [8192];

  int total = 0;
  int bad   = 0;

  logic [15:0] rgb_s [64];
  logic        de_s  [64];
  logic        hs_s  [64];
  logic        vs_s  [64];
  logic        hs_e  [64];
  logic        vs_e  [64];
  logic        de_pre, de_post;
  int          en_cnt;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  screen_scan_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .lcd_de_in  (lcd_de_in),
    .lcd_hs_in  (lcd_hs_in),
    .lcd_vs_in  (lcd_vs_in),
    .h_pos      (h_pos),
    .v_pos      (v_pos),
    .lcd_de     (lcd_de),
    .lcd_hs     (lcd_hs),
    .lcd_vs     (lcd_vs),
    .lcd_rgb    (lcd_rgb),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ready  (cpu_ready),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: writes one word through the CPU port (display idle).
  task automatic cpu_write(input logic [12:0] a, input logic [15:0] d);
    lcd_de_in = 1'b0;
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = a;
    cpu_wdata = d;
    tick();
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
  endtask

  // Stimulus only: drives one active run of len pixels starting at h0 and
  // records outputs realigned by the 2-cycle latency.
  task automatic run_line(input int v, input int h0, input int len);
    lcd_de_in = 1'b0;
    lcd_hs_in = 1'b0;
    lcd_vs_in = 1'b0;
    cpu_req   = 1'b0;
    v_pos     = 10'(v);
    h_pos     = 10'(h0);
    tick();
    tick();
    en_cnt = 0;
    for (int i = 0; i < len + 2; i++) begin
      if (i == 1) de_pre = lcd_de;
      if (i >= 2) begin
        rgb_s[i-2] = lcd_rgb;
        de_s[i-2]  = lcd_de;
        hs_s[i-2]  = lcd_hs;
        vs_s[i-2]  = lcd_vs;
      end
      h_pos     = 10'(h0 + i);
      lcd_de_in = (i < len);
      lcd_hs_in = (i % 3 == 0);
      lcd_vs_in = (i % 5 == 1);
      if (i < len) begin
        hs_e[i] = lcd_hs_in;
        vs_e[i] = lcd_vs_in;
      end
      #1;
      if (ram_en) en_cnt++;
      tick();
    end
    de_post   = lcd_de;
    lcd_de_in = 1'b0;
    lcd_hs_in = 1'b0;
    lcd_vs_in = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    lcd_de_in = 1'b1;
    lcd_hs_in = 1'b1;
    lcd_vs_in = 1'b1;
    h_pos     = 10'd0;
    v_pos     = 10'd0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 13'd0;
    cpu_wdata = 16'd0;
    tick();
    tick();
    total++;
    if (lcd_rgb !== 16'h0000) begin
      bad++; $display("FAIL reset_rgb got=%h want=0000", lcd_rgb);
    end
    total++;
    if ({lcd_de, lcd_hs, lcd_vs} !== 3'b000) begin
      bad++; $display("FAIL reset_timing got=%b want=000", {lcd_de, lcd_hs, lcd_vs});
    end
    total++;
    if (cpu_rvalid !== 1'b0 || cpu_rdata !== 16'h0000) begin
      bad++; $display("FAIL reset_cpu rvalid=%b rdata=%h want 0/0000", cpu_rvalid, cpu_rdata);
    end
    lcd_de_in = 1'b0;
    lcd_hs_in = 1'b0;
    lcd_vs_in = 1'b0;
    reset     = 1'b1;
    tick();
  endtask

  task automatic test_first_word();
    cpu_write(13'h0000, 16'h0001);
    run_line(0, 0, 32);
    total++;
    if (rgb_s[0] !== 16'h0000) begin
      bad++; $display("FAIL first_pixel got=%h want=0000", rgb_s[0]);
    end
    for (int k = 1; k < 32; k++) begin
      total++;
      if (rgb_s[k] !== 16'hFFFF) begin
        bad++; $display("FAIL first_line_bg x=%0d got=%h want=ffff", k, rgb_s[k]);
      end
    end
    total++;
    if (de_pre !== 1'b0 || de_post !== 1'b0) begin
      bad++; $display("FAIL de_edges pre=%b post=%b want 0/0", de_pre, de_post);
    end
    for (int k = 0; k < 32; k++) begin
      total++;
      if (de_s[k] !== 1'b1 || hs_s[k] !== hs_e[k] || vs_s[k] !== vs_e[k]) begin
        bad++;
        $display("FAIL timing_delay x=%0d got de/hs/vs=%b%b%b want=1%b%b",
                 k, de_s[k], hs_s[k], vs_s[k], hs_e[k], vs_e[k]);
      end
    end
    total++;
    if (en_cnt !== 2) begin
      bad++; $display("FAIL fetch_count_line0 got=%0d want=2", en_cnt);
    end
  endtask

  task automatic test_row5();
    cpu_write({8'd5, 5'd2}, 16'h8000);
    run_line(5, 0, 48);
    for (int k = 0; k < 47; k++) begin
      total++;
      if (rgb_s[k] !== 16'hFFFF) begin
        bad++; $display("FAIL row5_bg x=%0d got=%h want=ffff", k, rgb_s[k]);
      end
    end
    total++;
    if (rgb_s[47] !== 16'h0000) begin
      bad++; $display("FAIL row5_x47 got=%h want=0000", rgb_s[47]);
    end
    total++;
    if (en_cnt !== 3) begin
      bad++; $display("FAIL fetch_count_row5 got=%0d want=3", en_cnt);
    end
  endtask

  task automatic test_border();
    run_line(260, 0, 32);
    for (int k = 0; k < 32; k++) begin
      total++;
      if (rgb_s[k] !== 16'h001F) begin
        bad++; $display("FAIL border x=%0d got=%h want=001f", k, rgb_s[k]);
      end
    end
    total++;
    if (en_cnt !== 0) begin
      bad++; $display("FAIL border_ram_en got=%0d want=0", en_cnt);
    end
  endtask

  task automatic test_cpu_blocked();
    cpu_write(13'h0100, 16'h1234);
    v_pos     = 10'd0;
    h_pos     = 10'd16;
    lcd_de_in = 1'b1;
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 13'h0100;
    #1;
    total++;
    if (cpu_ready !== 1'b0 || ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 13'h0001) begin
      bad++;
      $display("FAIL blocked_cycle ready=%b en=%b we=%b addr=%h want 0 1 0 0001",
               cpu_ready, ram_en, ram_we, ram_addr);
    end
    tick();
    h_pos = 10'd17;
    #1;
    total++;
    if (cpu_ready !== 1'b1 || ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 13'h0100) begin
      bad++;
      $display("FAIL grant_cycle ready=%b en=%b we=%b addr=%h want 1 1 0 0100",
               cpu_ready, ram_en, ram_we, ram_addr);
    end
    total++;
    if (cpu_rvalid !== 1'b0) begin
      bad++; $display("FAIL rvalid_early got=%b want=0", cpu_rvalid);
    end
    tick();
    cpu_req   = 1'b0;
    lcd_de_in = 1'b0;
    total++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'h1234) begin
      bad++; $display("FAIL read_return rvalid=%b rdata=%h want 1/1234", cpu_rvalid, cpu_rdata);
    end
    // Display fetch of word 0 changes ram_rdata; cpu_rdata must hold.
    lcd_de_in = 1'b1;
    h_pos     = 10'd0;
    tick();
    lcd_de_in = 1'b0;
    tick();
    total++;
    if (cpu_rvalid !== 1'b0 || cpu_rdata !== 16'h1234) begin
      bad++; $display("FAIL read_hold rvalid=%b rdata=%h want 0/1234", cpu_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_cpu_write_display();
    cpu_write(13'h0000, 16'hFFFF);
    total++;
    if (cpu_rvalid !== 1'b0) begin
      bad++; $display("FAIL write_rvalid got=%b want=0", cpu_rvalid);
    end
    run_line(0, 0, 16);
    for (int k = 0; k < 16; k++) begin
      total++;
      if (rgb_s[k] !== 16'h0000) begin
        bad++; $display("FAIL written_fg x=%0d got=%h want=0000", k, rgb_s[k]);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    cpu_write(13'h0001, 16'hFFFF);
    v_pos     = 10'd260;
    h_pos     = 10'd0;
    lcd_de_in = 1'b1;
    lcd_hs_in = 1'b1;
    lcd_vs_in = 1'b1;
    tick();
    tick();
    total++;
    if (lcd_rgb !== 16'h001F || lcd_de !== 1'b1) begin
      bad++; $display("FAIL pre_reset_out rgb=%h de=%b want 001f/1", lcd_rgb, lcd_de);
    end
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 13'h0100;
    #1;
    total++;
    if (cpu_ready !== 1'b1) begin
      bad++; $display("FAIL mid_read_grant got=%b want=1", cpu_ready);
    end
    #1;
    reset = 1'b0;
    #1;
    total++;
    if (lcd_rgb !== 16'h0000 || {lcd_de, lcd_hs, lcd_vs} !== 3'b000) begin
      bad++; $display("FAIL async_reset_video rgb=%h dhv=%b want 0000/000", lcd_rgb, {lcd_de, lcd_hs, lcd_vs});
    end
    total++;
    if (cpu_rvalid !== 1'b0 || cpu_rdata !== 16'h0000) begin
      bad++; $display("FAIL async_reset_cpu rvalid=%b rdata=%h want 0/0000", cpu_rvalid, cpu_rdata);
    end
    tick();
    total++;
    if (cpu_rvalid !== 1'b0 || lcd_de !== 1'b0 || lcd_rgb !== 16'h0000) begin
      bad++; $display("FAIL held_reset rvalid=%b de=%b rgb=%h want 0/0/0000", cpu_rvalid, lcd_de, lcd_rgb);
    end
    reset     = 1'b1;
    cpu_req   = 1'b0;
    lcd_de_in = 1'b0;
    lcd_hs_in = 1'b0;
    lcd_vs_in = 1'b0;
    tick();
    total++;
    if (cpu_rvalid !== 1'b0) begin
      bad++; $display("FAIL dropped_read_rvalid got=%b want=0", cpu_rvalid);
    end
  endtask

  task automatic test_reset_mid_line();
    // Word register was cleared by reset, so x=8..15 show BG before the next fetch.
    run_line(0, 8, 16);
    for (int k = 0; k < 8; k++) begin
      total++;
      if (rgb_s[k] !== 16'hFFFF) begin
        bad++; $display("FAIL midline_bg x=%0d got=%h want=ffff", k + 8, rgb_s[k]);
      end
    end
    for (int k = 8; k < 16; k++) begin
      total++;
      if (rgb_s[k] !== 16'h0000) begin
        bad++; $display("FAIL midline_fg x=%0d got=%h want=0000", k + 8, rgb_s[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_row5();
    test_border();
    test_cpu_blocked();
    test_cpu_write_display();
    test_reset_mid_read();
    test_reset_mid_line();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
